// File: rtl/rmii_loop_pkg.sv
// Shared types and helpers for the RMII PHY-side loopback model.
//   fifo_entry_t : one buffered byte plus its end-of-frame tag
//   state_t      : replay FSM states
//   dibit_of()   : selects dibit idx (LSB-first) from a byte
package rmii_loop_pkg;

  localparam int DIBITS_PER_BYTE = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    GAP
  } state_t;

  function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/rmii_loop_fifo.sv
// Show-ahead synchronous FIFO of fifo_entry_t.
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   push_i, push_data_i  write request and entry (ignored when full)
//   pop_i                read request (ignored when empty)
//   head_o               entry at the read pointer, valid when !empty_o
//   full_o, empty_o      occupancy flags
//   count_o              number of stored entries
module rmii_loop_fifo
  import rmii_loop_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  fifo_entry_t                push_data_i,
  input  logic                       pop_i,
  output fifo_entry_t                head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fifo_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/rmii_phy_loopback.sv
// PHY-side RMII loopback: captures TX dibits into bytes, buffers them in a
// cut-through FIFO and replays them as an RMII RX stream.
// Ports:
//   ref_clk, rst            50 MHz reference clock, async active-high reset
//   enable                  loopback enable, sampled when tx_en rises
//   rmii_txd, rmii_tx_en    TX dibit stream from the MAC-side converter
//   rmii_rxd, rmii_crs_dv,
//   rmii_rx_err             replayed RX stream (registered)
//   frame_cnt               frames replayed completely
//   overflow, underflow,
//   align_err               sticky error flags
//
// state | meaning
// IDLE  | waiting for START_THRESH bytes or a complete short frame
// SEND  | replaying head entry one dibit per cycle
// DRAIN | underflow recovery: signal rx_err, discard until end of frame
// GAP   | inter-frame gap, crs_dv low for IFG_DIBITS cycles
module rmii_phy_loopback
  import rmii_loop_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int START_THRESH = 4,
  parameter int IFG_DIBITS   = 48
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmii_txd,
  input  logic        rmii_tx_en,
  output logic [1:0]  rmii_rxd,
  output logic        rmii_crs_dv,
  output logic        rmii_rx_err,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  output logic        underflow,
  output logic        align_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(IFG_DIBITS + 1);
  localparam logic [1:0] LAST_DIBIT = 2'(DIBITS_PER_BYTE - 1);

  // ---------------- capture side ----------------
  logic        tx_en_q;
  logic        admit_q;
  logic [1:0]  cap_cnt_q;
  logic [5:0]  cap_sr_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        align_err_q;
  logic        overflow_q;

  logic        tx_rise;
  logic        tx_fall;
  logic        take;
  logic        byte_done;
  logic        fall_admit;
  logic        push;
  logic        push_ok;
  fifo_entry_t push_entry;

  // fifo
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        pop;

  assign tx_rise    = rmii_tx_en & ~tx_en_q;
  assign tx_fall    = ~rmii_tx_en & tx_en_q;
  // Admission is decided on the rising edge itself so the first dibit is
  // not lost; afterwards the latched decision holds for the whole frame.
  assign take       = rmii_tx_en & (tx_rise ? enable : admit_q);
  assign byte_done  = take & (cap_cnt_q == LAST_DIBIT);
  assign fall_admit = tx_fall & admit_q;
  assign push       = hold_vld_q & (byte_done | fall_admit);
  assign push_ok    = push & ~fifo_full;
  assign push_entry = '{last: fall_admit, data: hold_q};

  // tx_en_q resets high: a frame already in progress when reset releases
  // is never seen as a rising edge, so its tail is ignored.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      tx_en_q     <= 1'b1;
      admit_q     <= 1'b0;
      cap_cnt_q   <= '0;
      cap_sr_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      align_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      tx_en_q <= rmii_tx_en;
      if (tx_rise) admit_q <= enable;
      if (take) begin
        cap_cnt_q <= cap_cnt_q + 2'd1;
        if (byte_done) begin
          hold_q     <= {rmii_txd, cap_sr_q};
          hold_vld_q <= 1'b1;
        end else begin
          cap_sr_q <= {rmii_txd, cap_sr_q[5:2]};
        end
      end
      if (tx_fall) begin
        cap_cnt_q  <= '0;
        hold_vld_q <= 1'b0;
        if (admit_q && cap_cnt_q != '0) align_err_q <= 1'b1;
      end
      if (push && fifo_full) overflow_q <= 1'b1;
    end
  end

  rmii_loop_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (ref_clk),
    .rst_i      (rst),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // ---------------- replay FSM ----------------
  state_t        state_q, state_d;
  logic [1:0]    rd_cnt_q, rd_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    rxd_q, rxd_d;
  logic          crs_dv_q, crs_dv_d;
  logic          rx_err_q, rx_err_d;
  logic [15:0]   frame_cnt_q;
  logic          underflow_q;
  logic [CW-1:0] last_cnt_q;
  logic          frame_inc;
  logic          underflow_set;

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    gap_d         = gap_q;
    rxd_d         = 2'b00;
    crs_dv_d      = 1'b0;
    rx_err_d      = 1'b0;
    pop           = 1'b0;
    frame_inc     = 1'b0;
    underflow_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count >= CW'(START_THRESH) || last_cnt_q != '0) begin
          state_d  = SEND;
          rxd_d    = dibit_of(head.data, 2'd0);
          crs_dv_d = 1'b1;
          rd_cnt_d = 2'd1;
        end
      end
      SEND: begin
        crs_dv_d = 1'b1;
        if (rd_cnt_q == 2'd0 && fifo_empty) begin
          underflow_set = 1'b1;
          rx_err_d      = 1'b1;
          state_d       = DRAIN;
        end else begin
          rxd_d = dibit_of(head.data, rd_cnt_q);
          if (rd_cnt_q == LAST_DIBIT) begin
            pop      = 1'b1;
            rd_cnt_d = 2'd0;
            if (head.last) begin
              state_d   = GAP;
              gap_d     = GW'(IFG_DIBITS - 1);
              frame_inc = 1'b1;
            end
          end else begin
            rd_cnt_d = rd_cnt_q + 2'd1;
          end
        end
      end
      DRAIN: begin
        crs_dv_d = 1'b1;
        rx_err_d = 1'b1;
        // Remaining bytes of the broken frame are discarded as they arrive.
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.last) begin
            state_d = GAP;
            gap_d   = GW'(IFG_DIBITS - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      gap_q       <= '0;
      rxd_q       <= '0;
      crs_dv_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_cnt_q <= '0;
      underflow_q <= 1'b0;
      last_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      gap_q    <= gap_d;
      rxd_q    <= rxd_d;
      crs_dv_q <= crs_dv_d;
      rx_err_q <= rx_err_d;
      if (frame_inc)     frame_cnt_q <= frame_cnt_q + 16'd1;
      if (underflow_set) underflow_q <= 1'b1;
      // Number of complete frames buffered; lets short frames start early.
      last_cnt_q <= last_cnt_q + CW'(push_ok & push_entry.last) - CW'(pop & head.last);
    end
  end

  assign rmii_rxd    = rxd_q;
  assign rmii_crs_dv = crs_dv_q;
  assign rmii_rx_err = rx_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_rmii_phy_loopback.sv
module tb_rmii_phy_loopback;

  localparam int IFG = 48;

  logic        ref_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  rmii_txd = 2'b00;
  logic        rmii_tx_en = 1'b0;
  logic [1:0]  rmii_rxd;
  logic        rmii_crs_dv;
  logic        rmii_rx_err;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic        underflow;
  logic        align_err;

  rmii_phy_loopback dut (
    .ref_clk    (ref_clk),
    .rst        (rst),
    .enable     (enable),
    .rmii_txd   (rmii_txd),
    .rmii_tx_en (rmii_tx_en),
    .rmii_rxd   (rmii_rxd),
    .rmii_crs_dv(rmii_crs_dv),
    .rmii_rx_err(rmii_rx_err),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow),
    .underflow  (underflow),
    .align_err  (align_err)
  );

  always #10 ref_clk = ~ref_clk;

  int cyc = 0;
  always @(posedge ref_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  logic [7:0] tx_bytes[$];
  bit         sb_on = 1'b1;

  // monitor state
  bit         crs_prev = 1'b0;
  bit         seen_fall = 1'b0;
  bit         rx_err_seen = 1'b0;
  int         run_cnt = 0;
  int         run_len = 0;
  int         last_run_len = 0;
  int         low_len = 0;
  int         min_gap = 1000000;
  int         rise_cyc = 0;
  int         tx_start_cyc = 0;
  logic [1:0] first_dibit = 2'b00;

  // Scoreboard consumer: each valid replayed dibit pops the next expected one.
  always @(negedge ref_clk) begin
    if (rmii_crs_dv) begin
      if (!crs_prev) begin
        run_cnt++;
        rise_cyc    = cyc;
        run_len     = 0;
        first_dibit = rmii_rxd;
        if (seen_fall && low_len < min_gap) min_gap = low_len;
      end
      run_len++;
      if (rmii_rx_err) rx_err_seen = 1'b1;
      else if (sb_on) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got dibit %b at cycle %0d, required no output", rmii_rxd, cyc);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (rmii_rxd !== e) begin
            errors++;
            $display("FAIL sb_dibit: got %b required %b at cycle %0d", rmii_rxd, e, cyc);
          end
        end
      end
    end else begin
      if (crs_prev) begin
        seen_fall    = 1'b1;
        last_run_len = run_len;
        low_len      = 0;
      end
      low_len++;
    end
    crs_prev = rmii_crs_dv;
  end

  task automatic clear_mon();
    crs_prev     = 1'b0;
    seen_fall    = 1'b0;
    rx_err_seen  = 1'b0;
    run_cnt      = 0;
    run_len      = 0;
    last_run_len = 0;
    low_len      = 0;
    min_gap      = 1000000;
  endtask

  task automatic do_reset();
    @(negedge ref_clk);
    rmii_tx_en = 1'b0;
    rmii_txd   = 2'b00;
    enable     = 1'b1;
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    exp_q.delete();
    sb_on = 1'b1;
    clear_mon();
  endtask

  task automatic send_frame(input int extra, input bit expect_out);
    for (int b = 0; b < tx_bytes.size(); b++) begin
      for (int d = 0; d < 4; d++) begin
        @(negedge ref_clk);
        if (b == 0 && d == 0) tx_start_cyc = cyc + 1;
        rmii_tx_en = 1'b1;
        rmii_txd   = tx_bytes[b][2*d +: 2];
        if (expect_out) exp_q.push_back(tx_bytes[b][2*d +: 2]);
      end
    end
    for (int x = 0; x < extra; x++) begin
      @(negedge ref_clk);
      rmii_txd = 2'b11;
    end
    @(negedge ref_clk);
    rmii_tx_en = 1'b0;
    rmii_txd   = 2'b00;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge ref_clk); #1;
      if (exp_q.size() == 0 && !rmii_crs_dv) ok = 1'b1;
    end
    repeat (IFG + 4) @(posedge ref_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge ref_clk);
    #1;
    checks++; if (rmii_rxd !== 2'b00)   begin errors++; $display("FAIL reset_rxd: got %b required 00", rmii_rxd); end
    checks++; if (rmii_crs_dv !== 1'b0) begin errors++; $display("FAIL reset_crs_dv: got %b required 0", rmii_crs_dv); end
    checks++; if (rmii_rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %b required 0", rmii_rx_err); end
    checks++; if (frame_cnt !== 16'd0)  begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if ({overflow, underflow, align_err} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: got %b required 000", {overflow, underflow, align_err}); end
    @(negedge ref_clk);
    rst = 1'b0;
  endtask

  task automatic test_long_frame();
    bit ok;
    do_reset();
    tx_bytes.delete();
    for (int i = 0; i < 7; i++) tx_bytes.push_back(8'h55);
    tx_bytes.push_back(8'hD5);
    for (int i = 0; i < 56; i++) tx_bytes.push_back(8'(i));
    send_frame(0, 1'b1);
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_timeout: left=%0d required 0", exp_q.size()); end
    checks++; if (rise_cyc - tx_start_cyc !== 20)
      begin errors++; $display("FAIL long_latency: got %0d required 20", rise_cyc - tx_start_cyc); end
    checks++; if (last_run_len !== 256) begin errors++; $display("FAIL long_crs_len: got %0d required 256", last_run_len); end
    checks++; if (run_cnt !== 1) begin errors++; $display("FAIL long_runs: got %0d required 1", run_cnt); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL long_frame_cnt: got %0d required 1", frame_cnt); end
    checks++; if ({overflow, underflow, align_err, rx_err_seen} !== 4'b0000)
      begin errors++; $display("FAIL long_flags: got %b required 0000", {overflow, underflow, align_err, rx_err_seen}); end
  endtask

  task automatic test_short_frame();
    bit ok;
    do_reset();
    tx_bytes.delete();
    tx_bytes.push_back(8'hA1);
    tx_bytes.push_back(8'hB2);
    tx_bytes.push_back(8'hC3);
    send_frame(0, 1'b1);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_timeout: left=%0d required 0", exp_q.size()); end
    // 12 TX dibits, fall seen on edge 12, replay visible after edge 13
    checks++; if (rise_cyc - tx_start_cyc !== 13)
      begin errors++; $display("FAIL short_latency: got %0d required 13", rise_cyc - tx_start_cyc); end
    checks++; if (first_dibit !== 2'b01) begin errors++; $display("FAIL short_first_dibit: got %b required 01", first_dibit); end
    checks++; if (last_run_len !== 12) begin errors++; $display("FAIL short_crs_len: got %0d required 12", last_run_len); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL short_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    tx_bytes.delete();
    for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i * 3 + 1));
    send_frame(0, 1'b1);
    repeat (IFG - 1) @(negedge ref_clk);
    tx_bytes.delete();
    for (int i = 0; i < 60; i++) tx_bytes.push_back(~8'(i * 5));
    send_frame(0, 1'b1);
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: left=%0d required 0", exp_q.size()); end
    checks++; if (run_cnt !== 2) begin errors++; $display("FAIL b2b_runs: got %0d required 2", run_cnt); end
    checks++; if (min_gap < IFG) begin errors++; $display("FAIL b2b_gap: got %0d required >= %0d", min_gap, IFG); end
    checks++; if (last_run_len !== 240) begin errors++; $display("FAIL b2b_crs_len: got %0d required 240", last_run_len); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
    checks++; if ({overflow, underflow, align_err} !== 3'b000)
      begin errors++; $display("FAIL b2b_flags: got %b required 000", {overflow, underflow, align_err}); end
  endtask

  task automatic test_align();
    bit ok;
    do_reset();
    tx_bytes.delete();
    for (int i = 0; i < 10; i++) tx_bytes.push_back(8'h30 + 8'(i));
    send_frame(2, 1'b1);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL align_timeout: left=%0d required 0", exp_q.size()); end
    checks++; if (last_run_len !== 40) begin errors++; $display("FAIL align_crs_len: got %0d required 40", last_run_len); end
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_flag: got %b required 1", align_err); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL align_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_enable();
    bit ok;
    do_reset();
    enable = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 8; i++) tx_bytes.push_back(8'h90 + 8'(i));
    fork
      send_frame(0, 1'b0);
      begin
        repeat (8) @(negedge ref_clk);
        enable = 1'b1;
      end
    join
    repeat (100) @(posedge ref_clk);
    #1;
    checks++; if (run_cnt !== 0) begin errors++; $display("FAIL en_blocked_runs: got %0d required 0", run_cnt); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL en_blocked_cnt: got %0d required 0", frame_cnt); end
    send_frame(0, 1'b1);
    wait_done(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_timeout: left=%0d required 0", exp_q.size()); end
    checks++; if (run_cnt !== 1) begin errors++; $display("FAIL en_runs: got %0d required 1", run_cnt); end
    checks++; if (last_run_len !== 32) begin errors++; $display("FAIL en_crs_len: got %0d required 32", last_run_len); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL en_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    sb_on = 1'b0;
    tx_bytes.delete();
    for (int i = 0; i < 100; i++) tx_bytes.push_back(8'(i + 7));
    fork
      send_frame(0, 1'b0);
      begin
        repeat (300) @(negedge ref_clk);
        #2;
        checks++; if (rmii_crs_dv !== 1'b1) begin errors++; $display("FAIL mid_pre_send: got crs_dv %b required 1", rmii_crs_dv); end
        rst = 1'b1;
        #1;
        checks++; if ({rmii_rxd, rmii_crs_dv, rmii_rx_err} !== 4'b0000)
          begin errors++; $display("FAIL mid_outputs: got %b required 0000", {rmii_rxd, rmii_crs_dv, rmii_rx_err}); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d required 0", frame_cnt); end
        #2 rst = 1'b0;
        clear_mon();
      end
    join
    repeat (100) @(posedge ref_clk);
    #1;
    checks++; if (run_cnt !== 0) begin errors++; $display("FAIL mid_tail_runs: got %0d required 0", run_cnt); end
    exp_q.delete();
    sb_on = 1'b1;
    tx_bytes.delete();
    for (int i = 0; i < 64; i++) tx_bytes.push_back(8'hC0 ^ 8'(i));
    send_frame(0, 1'b1);
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: left=%0d required 0", exp_q.size()); end
    checks++; if (rise_cyc - tx_start_cyc !== 20)
      begin errors++; $display("FAIL mid_latency: got %0d required 20", rise_cyc - tx_start_cyc); end
    checks++; if (last_run_len !== 256) begin errors++; $display("FAIL mid_crs_len: got %0d required 256", last_run_len); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame_cnt_after: got %0d required 1", frame_cnt); end
    checks++; if ({overflow, underflow, align_err, rx_err_seen} !== 4'b0000)
      begin errors++; $display("FAIL mid_flags: got %b required 0000", {overflow, underflow, align_err, rx_err_seen}); end
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_short_frame();
    test_back_to_back();
    test_align();
    test_enable();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
